// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: slot-based memory bus arbiter.
// Slots alternate between CPU-owned (even) and shared (odd). The owner is
// latched at ACCEPT_PH, held to slot end, and completions (ack) are
// combinational from DONE_PH onward. Also stretches the CPU reset
// instruction into a long active-low system reset.
module mem_slot_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int PHASES    = 8,
    parameter int ACCEPT_PH = 2,
    parameter int DONE_PH   = 4,
    parameter int RST_HOLD  = 65535,
    localparam int PW       = $clog2(PHASES),
    localparam int CW       = $clog2(RST_HOLD + 1)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clk8_en_p,
    input  logic              ext_reset_req,
    input  logic [NUM_CH-1:0] req,
    output logic [PW-1:0]     bus_phase,
    output logic              cycle_ready,
    output logic              slot_odd,
    output logic [NUM_CH-1:0] grant,
    output logic [NUM_CH-1:0] ack,
    output logic              n_sys_reset
);

    localparam logic [PW-1:0] L_ACCEPT = PW'(ACCEPT_PH);
    localparam logic [PW-1:0] L_DONE   = PW'(DONE_PH);
    localparam logic [PW-1:0] L_LAST   = PW'(PHASES - 1);
    localparam logic [CW-1:0] L_HOLD   = CW'(RST_HOLD);

    logic [PW-1:0]     r_phase;
    logic              r_odd;
    logic [NUM_CH-1:0] r_grant;
    logic [CW-1:0]     r_cnt;
    logic              r_nrst;

    logic [NUM_CH-1:0] w_next_grant;
    logic              w_found;
    logic              w_done;

    // Slot winner: shared slots go to the lowest non-CPU requester first,
    // the CPU only borrows them when no one else asks.
    always_comb begin
        w_next_grant = '0;
        w_found      = 1'b0;
        if (r_odd) begin
            for (int i = 1; i < NUM_CH; i++) begin
                if (req[i] && !w_found) begin
                    w_next_grant[i] = 1'b1;
                    w_found         = 1'b1;
                end
            end
        end
        if (!w_found && req[0]) begin
            w_next_grant[0] = 1'b1;
        end
    end

    // Phase counter, slot parity and grant latch; grant is held to slot
    // end even if the request drops, so no one else can steal the slot.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_phase <= '0;
            r_odd   <= 1'b0;
            r_grant <= '0;
        end else if (clk8_en_p) begin
            r_phase <= r_phase + PW'(1);
            if (r_phase == L_LAST) begin
                r_odd   <= ~r_odd;
                r_grant <= '0;
            end else if (r_phase == L_ACCEPT) begin
                r_grant <= w_next_grant;
            end
        end
    end

    // Reset stretcher: reload on request, count down, release one tick
    // after the count has reached zero.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt  <= L_HOLD;
            r_nrst <= 1'b0;
        end else if (clk8_en_p) begin
            if (ext_reset_req) begin
                r_cnt  <= L_HOLD;
                r_nrst <= 1'b0;
            end else if (r_cnt != '0) begin
                r_cnt  <= r_cnt - CW'(1);
            end else begin
                r_nrst <= 1'b1;
            end
        end
    end

    assign w_done = (r_phase >= L_DONE);

    // Per-channel completion strobe, dropped immediately when req falls.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ack
        assign ack[g] = r_grant[g] & req[g] & w_done;
    end

    assign bus_phase   = r_phase;
    assign cycle_ready = (r_phase == L_LAST);
    assign slot_odd    = r_odd;
    assign grant       = r_grant;
    assign n_sys_reset = r_nrst;

endmodule

// File: doc/mem_slot_arbiter.md
MEM_SLOT_ARBITER -- requirements
Module: mem_slot_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of memory clients (2..8); channel 0 is the CPU.
REQ-002 SHALL have parameter PHASES, default 8, bus phases per slot (power of two, 4..16).
REQ-003 SHALL have parameter ACCEPT_PH, default 2, phase at which requests are sampled for the current slot.
REQ-004 SHALL have parameter DONE_PH, default 4, first phase at which a granted access may complete (ACCEPT_PH < DONE_PH < PHASES).
REQ-005 SHALL have parameter RST_HOLD, default 65535, clk8_en_p ticks the system reset is stretched.
REQ-006 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clk8_en_p  in  1  8 MHz clock enable; phase and reset counters advance only when high.
REQ-009 ext_reset_req  in  1  active-high reset request from CPU reset instruction.
REQ-010 req  in  NUM_CH  per-channel level request; held until ack.
REQ-011 bus_phase  out  log2(PHASES)  current bus phase.
REQ-012 cycle_ready  out  1  high while bus_phase == PHASES-1.
REQ-013 slot_odd  out  1  0 = CPU-owned slot, 1 = shared slot.
REQ-014 grant  out  NUM_CH  one-hot (or zero) owner of current slot.
REQ-015 ack  out  NUM_CH  per-channel completion strobe (DTACK equivalent).
REQ-016 n_sys_reset  out  1  active-low stretched system reset.

Function
REQ-017 bus_phase SHALL increment by 1 on each clk8_en_p cycle, wrapping PHASES-1 -> 0; slot_odd SHALL toggle on each wrap.
REQ-018 On the clk8_en_p cycle with bus_phase == ACCEPT_PH, grant SHALL be registered; it SHALL be visible from phase ACCEPT_PH+1 to slot end and SHALL clear on the wrap to phase 0.
REQ-019 Even slot: grant = channel 0 if req[0] is sampled high, else zero.
REQ-020 Odd slot: grant = lowest-indexed i >= 1 with req[i] sampled high; if none, channel 0 borrows the slot when req[0] is high; else zero.
REQ-021 A request rising after the ACCEPT_PH sample SHALL NOT be granted in that slot; it waits for the next eligible slot.
REQ-022 ack[i] SHALL be combinational: grant[i] && req[i] && bus_phase >= DONE_PH; it remains high until slot end or req[i] falls.
REQ-023 If req[i] drops mid-slot, grant[i] SHALL be held to slot end, ack[i] SHALL go low immediately, and no other channel is granted in that slot.
REQ-024 At most one grant bit and at most one ack bit SHALL be high in any cycle.
REQ-025 Reset stretcher: on a clk8_en_p cycle with ext_reset_req high, the counter SHALL reload to RST_HOLD and n_sys_reset SHALL go 0; otherwise, while the counter is nonzero, it SHALL decrement per clk8_en_p; n_sys_reset SHALL be set to 1 on the first clk8_en_p cycle on which the counter is already zero.
REQ-026 ext_reset_req asserted while the counter is nonzero SHALL restart the count from RST_HOLD.
REQ-027 Arbitration SHALL continue while n_sys_reset is low; the stretcher does not gate the bus.

Reset
REQ-028 While reset is high, all of the following SHALL hold on the next clk_sys edge: bus_phase=0, slot_odd=0, grant=0, ack=0, n_sys_reset=0, stretch counter=RST_HOLD; clk8_en_p is ignored.
REQ-029 Reset asserted mid-slot SHALL abort the slot with no ack; the first slot after release is even (CPU).

Verification (NUM_CH=4, PHASES=8, ACCEPT_PH=2, DONE_PH=4, RST_HOLD=3, clk8_en_p every 2nd clk_sys)
REQ-030 req=0001 steady from reset -> even slot: grant=0001 at phase 3, ack[0]=1 phases 4..7; following odd slot: channel 0 borrows, grant=0001.
REQ-031 req=1110 present before phase 2 of odd slot -> grant=0010, ack=0010 at phases 4..7; the next odd slot grants 0100 after req[1] is dropped.
REQ-032 req[2] raised at phase 3 of odd slot -> no grant in that slot; grant=0100 in the next odd slot at phase 3.
REQ-033 req[1] dropped at phase 5 while granted -> ack[1] low the same cycle, grant held to phase 7, cleared at phase 0.
REQ-034 Release reset -> n_sys_reset=1 after 4 clk8_en_p ticks (3 decrements, then set); ext_reset_req pulse at tick 2 -> count restarts, n_sys_reset stays 0 for 4 more ticks.
REQ-035 Reset asserted at phase 5 with ack[0]=1 -> next cycle ack=0, grant=0, bus_phase=0, slot_odd=0.
